// File: rtl/cr_tlvp_usr_wr_arb_if.sv
// Bundle for the TLV user write arbiter: the requester side (valid/tlv/eot/ack)
// and the parser's user outbound write port (wr/tlv/full).
// The arbiter connects through the master modport because it drives the write
// port and the per-requester acks. Producers and the parser together connect
// through the slave modport.
interface cr_tlvp_usr_wr_arb_if #(
  parameter int N_REQ = 4,
  parameter int TLV_W = 64
);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*TLV_W-1:0] req_tlv;
  logic [N_REQ-1:0]       req_eot;
  logic [N_REQ-1:0]       req_ack;
  logic                   usr_full;
  logic                   usr_wr;
  logic [TLV_W-1:0]       usr_tlv;

  modport master (
    input  req_valid,
    input  req_tlv,
    input  req_eot,
    input  usr_full,
    output req_ack,
    output usr_wr,
    output usr_tlv
  );

  modport slave (
    output req_valid,
    output req_tlv,
    output req_eot,
    output usr_full,
    input  req_ack,
    input  usr_wr,
    input  usr_tlv
  );

endinterface

// File: rtl/cr_tlvp_usr_wr_arb.sv
// Round-robin, TLV-atomic arbiter sharing the TLV parser user outbound write
// port among N_REQ producers. A winner keeps the port until its end-of-TLV word
// is accepted. Each TLV costs one arbitration bubble. The write strobe and data
// are registered. The ack is combinational from usr_full and the owner's valid.
// Optional build macro CR_TLVP_USR_WR_ARB_STALL_CNT_EN adds a saturating
// backpressure stall counter (stall_cnt) with a synchronous clear (stall_cnt_clr).
module cr_tlvp_usr_wr_arb #(
  parameter int N_REQ = 4,
  parameter int TLV_W = 64,
  parameter int GID_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cr_tlvp_usr_wr_arb_if.master bus,
  output logic                 grant_vld,
  output logic [GID_W-1:0]     grant_id
`ifdef CR_TLVP_USR_WR_ARB_STALL_CNT_EN
  ,
  input  logic                 stall_cnt_clr,
  output logic [15:0]          stall_cnt
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [GID_W-1:0] rr_ptr;
  logic [GID_W-1:0] rr_nxt;
  logic [GID_W-1:0] gid_q;
  logic [GID_W-1:0] pick_idx;
  logic             pick_vld;

  logic             cur_valid;
  logic             cur_eot;
  logic [TLV_W-1:0] tlv_sel;

  logic             ack_now;
  logic [N_REQ-1:0] ack_vec;

  logic             usr_wr_q;
  logic [TLV_W-1:0] usr_tlv_q;

  // State register: IDLE arbitrates, XFER streams the owner's TLV.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Rotating-priority search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    logic [GID_W:0] cand;
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (GID_W+1)'(k);
      if (cand >= (GID_W+1)'(N_REQ)) begin
        cand = cand - (GID_W+1)'(N_REQ);
      end
      if (!pick_vld && bus.req_valid[cand[GID_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[GID_W-1:0];
      end
    end
  end

  // Mux the current owner's valid, eot and data word out of the flat buses.
  always_comb begin
    cur_valid = 1'b0;
    cur_eot   = 1'b0;
    tlv_sel   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gid_q == GID_W'(i)) begin
        cur_valid = bus.req_valid[i];
        cur_eot   = bus.req_eot[i];
        tlv_sel   = bus.req_tlv[i*TLV_W +: TLV_W];
      end
    end
  end

  // Next-state: leave IDLE on any request, return once the eot word is accepted.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (ack_now && cur_eot) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: one-hot pop to the owner only, gated by the parser's full flag.
  always_comb begin
    ack_vec = '0;
    ack_now = 1'b0;
    if (state == XFER && cur_valid && !bus.usr_full) begin
      ack_now        = 1'b1;
      ack_vec[gid_q] = 1'b1;
    end
  end

  assign rr_nxt = (gid_q == GID_W'(N_REQ-1)) ? '0 : gid_q + 1'b1;

  // Registered write port, owner index and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      usr_wr_q  <= 1'b0;
      usr_tlv_q <= '0;
      gid_q     <= '0;
      rr_ptr    <= '0;
    end else begin
      usr_wr_q <= ack_now;
      if (ack_now) begin
        usr_tlv_q <= tlv_sel;
      end
      if (state == IDLE && pick_vld) begin
        gid_q <= pick_idx;
      end
      if (ack_now && cur_eot) begin
        rr_ptr <= rr_nxt;
      end
    end
  end

  assign bus.req_ack = ack_vec;
  assign bus.usr_wr  = usr_wr_q;
  assign bus.usr_tlv = usr_tlv_q;
  assign grant_vld   = (state == XFER);
  assign grant_id    = gid_q;

`ifdef CR_TLVP_USR_WR_ARB_STALL_CNT_EN
  logic stall_now;

  assign stall_now = (state == XFER) && cur_valid && bus.usr_full;

  // Saturating count of owner-ready cycles lost to parser backpressure; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_cnt_clr) begin
      stall_cnt <= '0;
    end else if (stall_now && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cr_tlvp_usr_wr_arb.sv
// Directed bench for cr_tlvp_usr_wr_arb: per-requester word queues feed the
// arbiter, expected words go into a scoreboard when stimulus is queued and are
// popped when usr_wr fires. Define CR_TLVP_USR_WR_ARB_STALL_CNT_EN to also
// cover the stall counter.
module tb_cr_tlvp_usr_wr_arb;

  localparam int N_REQ = 4;
  localparam int TLV_W = 64;
  localparam int GID_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             grant_vld;
  logic [GID_W-1:0] grant_id;
`ifdef CR_TLVP_USR_WR_ARB_STALL_CNT_EN
  logic             stall_cnt_clr;
  logic [15:0]      stall_cnt;
`endif

  cr_tlvp_usr_wr_arb_if #(.N_REQ(N_REQ), .TLV_W(TLV_W)) bus ();

  cr_tlvp_usr_wr_arb #(.N_REQ(N_REQ), .TLV_W(TLV_W), .GID_W(GID_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .grant_vld     (grant_vld),
    .grant_id      (grant_id)
`ifdef CR_TLVP_USR_WR_ARB_STALL_CNT_EN
    ,
    .stall_cnt_clr (stall_cnt_clr),
    .stall_cnt     (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [63:0] exp_q [$];
  int          wr_cyc [$];

  logic [63:0] mem_tlv [N_REQ][32];
  logic        mem_eot [N_REQ][32];
  int          rd [N_REQ];
  int          wr [N_REQ];

  logic [N_REQ-1:0]       rv;
  logic [N_REQ*TLV_W-1:0] rt;
  logic [N_REQ-1:0]       re;

  always @(posedge clk) cyc <= cyc + 1;

  // Requester models: present the head word of each queue, pop on ack.
  always_comb begin
    rv = '0;
    rt = '0;
    re = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (rd[i] != wr[i]) rv[i] = 1'b1;
      rt[i*TLV_W +: TLV_W] = mem_tlv[i][rd[i] % 32];
      re[i] = mem_eot[i][rd[i] % 32];
    end
  end

  assign bus.req_valid = rv;
  assign bus.req_tlv   = rt;
  assign bus.req_eot   = re;

  always @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (bus.req_ack[i] === 1'b1) rd[i] <= rd[i] + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int r, input logic [63:0] base, input int n);
    for (int j = 0; j < n; j++) begin
      mem_tlv[r][wr[r] % 32] = base + 64'(j);
      mem_eot[r][wr[r] % 32] = (j == n - 1);
      wr[r] = wr[r] + 1;
    end
  endtask

  task automatic expectTlv(input logic [63:0] base, input int n);
    for (int j = 0; j < n; j++) exp_q.push_back(base + 64'(j));
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  // Scoreboard monitor: every accepted write must match the next expected word.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.usr_wr === 1'b1) begin
      wr_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_write", bus.usr_tlv, 64'hDEAD_DEAD_DEAD_DEAD);
      end else begin
        checkOutput("usr_tlv", bus.usr_tlv, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w0;
    int pat [10] = '{0, 1, 3, 4, 6, 7, 9, 10, 12, 13};

    rst_n        = 1'b0;
    bus.usr_full = 1'b0;
`ifdef CR_TLVP_USR_WR_ARB_STALL_CNT_EN
    stall_cnt_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);

    // Reset state
    checkOutput("rst_usr_wr",    64'(bus.usr_wr),  64'd0);
    checkOutput("rst_usr_tlv",   bus.usr_tlv,      64'd0);
    checkOutput("rst_grant_vld", 64'(grant_vld),   64'd0);
    checkOutput("rst_grant_id",  64'(grant_id),    64'd0);
    checkOutput("rst_req_ack",   64'(bus.req_ack), 64'd0);
`ifdef CR_TLVP_USR_WR_ARB_STALL_CNT_EN
    checkOutput("rst_stall_cnt", 64'(stall_cnt),   64'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Single requester, 3-word TLV
    applyStimulus(0, 64'h0000_00A0, 3);
    expectTlv(64'h0000_00A0, 3);
    @(negedge clk);
    checkOutput("t1_grant_vld", 64'(grant_vld),   64'd1);
    checkOutput("t1_grant_id",  64'(grant_id),    64'd0);
    checkOutput("t1_bubble_wr", 64'(bus.usr_wr),  64'd0);
    checkOutput("t1_req_ack",   64'(bus.req_ack), 64'b0001);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("t1_wr_run", 64'(bus.usr_wr), 64'd1);
    end
    checkOutput("t1_release", 64'(grant_vld), 64'd0);
    @(negedge clk);
    checkOutput("t1_wr_end",  64'(bus.usr_wr), 64'd0);
    checkOutput("t1_gid_hold", 64'(grant_id),  64'd0);
    waitDrain(10);

    // rr_ptr is 1 now: req 1 beats req 0
    applyStimulus(0, 64'h0000_00B0, 1);
    applyStimulus(1, 64'h0000_00C0, 1);
    expectTlv(64'h0000_00C0, 1);
    expectTlv(64'h0000_00B0, 1);
    @(negedge clk);
    checkOutput("t2_grant_id", 64'(grant_id), 64'd1);
    waitDrain(20);

    // Serve req 2 to move rr_ptr to 3
    applyStimulus(2, 64'h0000_00D0, 1);
    expectTlv(64'h0000_00D0, 1);
    @(negedge clk);
    checkOutput("t3_grant_id", 64'(grant_id), 64'd2);
    waitDrain(20);

    // Wrap from rr_ptr=3 to req 0 with a single-word TLV
    w0 = wr_cyc.size();
    applyStimulus(0, 64'h0000_00E0, 1);
    expectTlv(64'h0000_00E0, 1);
    @(negedge clk);
    checkOutput("t4_wrap_grant", 64'(grant_id), 64'd0);
    waitDrain(20);
    repeat (2) @(negedge clk);
    checkOutput("t4_one_write", 64'(wr_cyc.size() - w0), 64'd1);
    checkOutput("t4_idle", 64'(grant_vld), 64'd0);

    // Atomicity: rr_ptr=1, req 1 (4 words) wins over req 0; req 3 joins mid-TLV
    w0 = wr_cyc.size();
    applyStimulus(1, 64'h0000_0100, 4);
    applyStimulus(0, 64'h0000_0200, 2);
    expectTlv(64'h0000_0100, 4);
    @(negedge clk);
    checkOutput("t5_grant_id", 64'(grant_id),    64'd1);
    checkOutput("t5_req_ack",  64'(bus.req_ack), 64'b0010);
    @(negedge clk);
    applyStimulus(3, 64'h0000_0300, 2);
    expectTlv(64'h0000_0300, 2);
    expectTlv(64'h0000_0200, 2);
    waitDrain(40);
    for (int k = 1; k < 4; k++) begin
      checkOutput("t5_contiguous", 64'(wr_cyc[w0+k] - wr_cyc[w0]), 64'(k));
    end
    checkOutput("t5_bubble", 64'(wr_cyc[w0+4] - wr_cyc[w0+3]), 64'd2);

    // Fairness: all requesters valid, 2-word TLVs, rotation starts at rr_ptr=1
    w0 = wr_cyc.size();
    applyStimulus(0, 64'h0000_0400, 2);
    applyStimulus(1, 64'h0000_0500, 2);
    applyStimulus(1, 64'h0000_0510, 2);
    applyStimulus(2, 64'h0000_0600, 2);
    applyStimulus(3, 64'h0000_0700, 2);
    expectTlv(64'h0000_0500, 2);
    expectTlv(64'h0000_0600, 2);
    expectTlv(64'h0000_0700, 2);
    expectTlv(64'h0000_0400, 2);
    expectTlv(64'h0000_0510, 2);
    waitDrain(60);
    for (int k = 0; k < 10; k++) begin
      checkOutput("t6_fair_timing", 64'(wr_cyc[w0+k] - wr_cyc[w0]), 64'(pat[k]));
    end

    // Backpressure: full for 5 cycles while word 2 of 3 is pending
    w0 = wr_cyc.size();
    applyStimulus(2, 64'h0000_0800, 3);
    expectTlv(64'h0000_0800, 3);
    @(negedge clk);
    checkOutput("t7_grant_id", 64'(grant_id), 64'd2);
    @(negedge clk);
    bus.usr_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput("t7_bp_ack", 64'(bus.req_ack), 64'd0);
      @(negedge clk);
      checkOutput("t7_bp_wr", 64'(bus.usr_wr), 64'd0);
    end
    bus.usr_full = 1'b0;
    waitDrain(20);
    checkOutput("t7_write_count", 64'(wr_cyc.size() - w0), 64'd3);
    checkOutput("t7_resume_gap", 64'(wr_cyc[w0+1] - wr_cyc[w0]), 64'd6);
`ifdef CR_TLVP_USR_WR_ARB_STALL_CNT_EN
    checkOutput("t7_stall_cnt", 64'(stall_cnt), 64'd5);
`endif

    // Reset during word 2 of a 4-word TLV from req 3 (rr_ptr=3)
    applyStimulus(3, 64'h0000_0900, 4);
    expectTlv(64'h0000_0900, 1);
    @(negedge clk);
    checkOutput("t8_grant_id", 64'(grant_id), 64'd3);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t8_rst_wr",    64'(bus.usr_wr),  64'd0);
    checkOutput("t8_rst_gvld",  64'(grant_vld),   64'd0);
    checkOutput("t8_rst_ack",   64'(bus.req_ack), 64'd0);
    checkOutput("t8_partial",   64'(exp_q.size()), 64'd0);
`ifdef CR_TLVP_USR_WR_ARB_STALL_CNT_EN
    checkOutput("t8_rst_stall", 64'(stall_cnt),   64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    wr[3] = rd[3];
    applyStimulus(1, 64'h0000_0A00, 1);
    applyStimulus(3, 64'h0000_0B00, 1);
    expectTlv(64'h0000_0A00, 1);
    expectTlv(64'h0000_0B00, 1);
    @(negedge clk);
    checkOutput("t8_rr_reset_grant", 64'(grant_id), 64'd1);
    waitDrain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cr_tlvp_usr_wr_arb.md
Name: cr_tlvp_usr_wr_arb

Overview:
- Round-robin arbiter that shares the single TLV parser user-outbound write port (usr_wr / usr_tlv / usr_full) among N_REQ requesters.
- Grants are TLV-atomic: once a requester wins, it keeps the port until its end-of-TLV word is accepted.
- Sits between the user-side TLV producers and the TLV parser's user outbound FIFO.
- Output is registered; flow control is driven by the parser's full flag.

Parameters:
N_REQ, 4, number of requesters (2..8).
TLV_W, 64, packed width of one TLV bus word as carried on usr_tlv.
GID_W, 2, width of grant index; must equal clog2(N_REQ).

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  N_REQ  requester i has a TLV word available.
req_tlv  in  N_REQ*TLV_W  word from requester i, in slice [i*TLV_W +: TLV_W].
req_eot  in  N_REQ  the current word of requester i is the last word of its TLV.
req_ack  out  N_REQ  one-hot pop; word i is consumed this cycle.
usr_full  in  1  parser user outbound FIFO full; parser is sized so afull leaves at least 2 entries of slack.
usr_wr  out  1  registered write strobe to the parser.
usr_tlv  out  TLV_W  registered write data.
grant_vld  out  1  a requester currently owns the port.
grant_id  out  GID_W  index of the owner; holds its last value when grant_vld=0.

Behaviour:
- Reset values: req_ack=0, usr_wr=0, usr_tlv=0, grant_vld=0, grant_id=0, rr_ptr=0, state=IDLE.
- State IDLE:
  - If any req_valid bit is set, pick the first set bit at or after rr_ptr, wrapping modulo N_REQ.
  - Register it as grant_id, set grant_vld=1, go to XFER.
  - No word is accepted in this cycle, so there is a 1-cycle arbitration bubble per TLV.
- State XFER, with g = grant_id:
  - req_ack[g] = req_valid[g] && !usr_full. The ack is combinational; all other ack bits are 0.
  - On ack: next cycle usr_wr=1 and usr_tlv=req_tlv[g]. Without ack: usr_wr=0 next cycle and usr_tlv holds.
  - Latency from ack to usr_wr is 1 cycle.
  - On ack with req_eot[g]=1: rr_ptr=(g+1) mod N_REQ, grant_vld=0, go to IDLE.
  - A single-word TLV (eot on the first word) is legal.
- Requesters not granted are never acked, whatever their valid state.
- Requester contract: req_tlv and req_eot are stable while req_valid=1 and not acked. If req_valid drops mid-TLV, the grant is kept, no timeout, and the arbiter waits indefinitely.
- usr_full=1 stalls the transfer: no ack, no write. Because only one write is in flight, the parser's full flag suffices; the arbiter never writes while usr_full=1 was sampled in the ack cycle.
- Simultaneous requests: rotating priority starts at rr_ptr. After serving g, the next search starts at g+1, so no requester starves while others hold TLVs of finite length.
- Wrap: with rr_ptr=N_REQ-1 and only requester 0 valid, grant goes to 0.
- Asynchronous reset mid-TLV: all state returns to reset values immediately. A partial TLV already written is not completed; recovery is the parser's job.
- There is no combinational path from usr_full to usr_wr. req_ack depends combinationally on usr_full and req_valid[g].

Optional Feature:
Macro CR_TLVP_USR_WR_ARB_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [15:0], reset 0.
  - Increments each XFER cycle where req_valid[g]=1 and usr_full=1; saturates at 16'hFFFF.
  - Adds input stall_cnt_clr (1 bit), which synchronously zeroes the counter. Clear wins over a simultaneous increment.
- Not defined: neither port exists and the logic is removed. Arbitration behaviour is identical in both builds.

Test Plan:
- Single requester: req 0 sends a 3-word TLV A,B,C (eot on C), usr_full=0 -> grant_id=0 one cycle after req_valid; usr_wr high for 3 consecutive cycles carrying A,B,C; back to IDLE; rr_ptr=1.
- Fairness: all 4 requesters continuously valid, each TLV 2 words -> usr_tlv source order 0,0,1,1,2,2,3,3,0,0; one idle cycle between TLVs.
- Atomicity: req 1 granted, req 0 asserts valid mid-TLV, req 1's 4-word TLV continues -> all 4 words of req 1 are contiguous on usr_tlv; req 0 is granted only after req 1's eot.
- Backpressure: usr_full=1 for 5 cycles during word 2 of 3 -> req_ack=0 and usr_wr=0 for those 5 cycles; word 2 is written in the cycle after usr_full falls; no duplicated or lost word. With the macro defined, stall_cnt=5.
- Wrap and single-word TLVs: rr_ptr=3, only req 0 valid with eot on its first word -> grant_id=0, one usr_wr, rr_ptr=1.
- Reset mid-TLV: rst_n low during word 2 of a 4-word TLV -> usr_wr=0, grant_vld=0, req_ack=0 immediately. After release, a new request is arbitrated from rr_ptr=0.
